capture_ctrl: RTL
=================

Name: capture_ctrl

Overview:
- Sequences acquisition of ADC samples into the three shared channel RAMs (common en/we/addr), using a 512-entry circular buffer with a programmable pre-trigger depth.
- Detects the selected trigger edge and stops after the post-trigger quota.
- After capture, owns RAM read arbitration so the host can dump samples in chronological order.
- Sits in the digital core between the command module (start/abort/config) and the RAM blocks.

Parameters:
- AW, 9, RAM address width
- DEPTH, 512, buffer entries; must equal 2**AW
- DECW, 4, decimation field width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start_capture  input  1  one-cycle pulse; begins acquisition
- abort  input  1  one-cycle pulse; cancels acquisition
- trig_pos  input  AW  pre-trigger sample count; latched at start
- decimate  input  DECW  a sample is taken every decimate+1 clocks; latched at start
- trig_src  input  1  0=trig1, 1=trig2; latched at start
- trig_edge  input  1  0=rising, 1=falling; latched at start
- force_trig  input  1  treated as a trigger event while ARMED
- trig1, trig2  input  1  asynchronous comparator outputs
- rd_req  input  1  read request, honoured only in DONE
- rd_idx  input  AW  chronological index (0 = oldest sample)
- en  output  1  RAM enable
- we  output  1  RAM write enable
- addr  output  AW  RAM address
- rd_valid  output  1  RAM data valid, one cycle after accepted rd_req
- armed  output  1  high in ARMED
- triggered  output  1  high in POSTTRIG and DONE
- capture_done  output  1  high in DONE
- trig_addr  output  AW  RAM address of the trigger sample

Behaviour:
- Reset:
  - state=IDLE.
  - en, we, rd_valid, armed, triggered, capture_done = 0.
  - addr=0, trig_addr=0.
  - All counters, write pointer and synchronizers cleared.
- Trigger path:
  - trig1 and trig2 each pass through a 2-flop synchronizer.
  - The selected signal is edge-detected against its previous synchronized value.
  - Event = selected edge OR force_trig.
  - Latency from trig pin to event is 3 clk.
- Sample tick:
  - div_cnt is loaded with decimate on entry to PRETRIG and on each tick.
  - A tick is asserted when div_cnt==0, otherwise div_cnt decrements.
  - decimate=0 gives a tick every clk.
- Write cycle (PRETRIG/ARMED/POSTTRIG on a tick):
  - en=1, we=1, addr=wr_ptr, all for exactly one clk (registered outputs).
  - wr_ptr increments modulo DEPTH (wraps 511->0).
  - en=0 and we=0 on non-tick cycles.
- States:
  - IDLE:
    - start_capture -> PRETRIG.
    - On this transition: latch config, wr_ptr=0, pre_cnt=0.
  - PRETRIG:
    - Each write increments pre_cnt.
    - When a write makes pre_cnt==trig_pos -> ARMED.
    - trig_pos==0 goes to ARMED on the cycle after start, with no PRETRIG writes.
  - ARMED:
    - Circular writes continue.
    - On event: trig_addr=wr_ptr, post_cnt=DEPTH-trig_pos -> POSTTRIG.
    - The trigger sample is the next write, at address trig_addr.
    - Events during PRETRIG are ignored.
  - POSTTRIG:
    - Each write decrements post_cnt.
    - The write that takes post_cnt to 0 -> DONE.
  - DONE:
    - capture_done=1 until start_capture (-> PRETRIG, re-arm) or rst.
    - Writes are disabled.
- Readback (DONE only):
  - rd_req drives en=1, we=0, addr=(trig_addr - trig_pos + rd_idx) mod DEPTH, registered.
  - rd_valid=1 on the following clk.
  - rd_req in any other state is ignored and rd_valid stays 0.
- Abort:
  - Any state -> IDLE on the next clk.
  - en=we=0 in that same next clk.
  - Captured data is not valid.
- Simultaneous events:
  - abort has priority over start_capture and over trigger.
  - start_capture outside IDLE/DONE is ignored.
  - Trigger on the same clk as a tick in ARMED: the write proceeds at the old wr_ptr, trig_addr = incremented wr_ptr.
  - rd_req and start_capture together in DONE: start wins and the read is dropped.
  - Config inputs changing mid-capture have no effect.
- Exactly DEPTH samples are written from the trigger sample's pre-history window: trig_pos before it, DEPTH-trig_pos including and after it.

Test Plan:
- trig_pos=100, decimate=0, rising trig1 pulse 300 clk after start:
  - exactly 512 total... PRETRIG ends after writes to addr 0..99, armed=1 at the next clk.
  - trig_addr equals wr_ptr at event.
  - POSTTRIG issues 412 writes.
  - capture_done asserts after the last write.
- decimate=3, trig_pos=4:
  - we pulses every 4th clk.
  - armed after 4 writes.
  - no write-enable on intervening clks.
- trig_pos=0, force_trig asserted 1 clk after armed:
  - trig_addr=0.
  - 512 writes to addr 0..511.
  - rd_req with rd_idx=0 gives addr=0 and rd_valid 1 clk later.
- Wrap case: trig_pos=10, trigger after 600 ARMED writes:
  - trig_addr=(10+600) mod 512=98.
  - rd_idx=0 maps to addr 88.
  - rd_idx=511 maps to addr 87.
- trig_edge=1, trig_src=1:
  - a rising trig2 edge and any activity on trig1 produce no trigger.
  - a falling trig2 edge triggers 3 clk later.
- abort during POSTTRIG (post_cnt=200):
  - IDLE next clk, en=we=0, capture_done=0.
  - A later start_capture restarts at wr_ptr=0.
  - rst mid-ARMED clears all outputs on the next clk.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// RAM-side bus of the capture controller: shared channel-RAM strobes plus the
// host readback request/valid handshake.
interface capture_ctrl_if #(
  parameter int AW = 9
) ();
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic          rd_req;
  logic [AW-1:0] rd_idx;
  logic          rd_valid;

  // Controller side: drives the RAM strobes, receives host read requests.
  modport master (
    output en, we, addr, rd_valid,
    input  rd_req, rd_idx
  );

  // RAM/host side.
  modport slave (
    input  en, we, addr, rd_valid,
    output rd_req, rd_idx
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills a circular sample buffer around a trigger event
// with a programmable pre-trigger depth, then arbitrates host readback in
// chronological order (index 0 = oldest sample).
module capture_ctrl #(
  parameter int AW    = 9,
  parameter int DEPTH = 512,
  parameter int DECW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_capture,
  input  logic            abort,
  input  logic [AW-1:0]   trig_pos,
  input  logic [DECW-1:0] decimate,
  input  logic            trig_src,
  input  logic            trig_edge,
  input  logic            force_trig,
  input  logic            trig1,
  input  logic            trig2,
  capture_ctrl_if.master  ram,
  output logic            armed,
  output logic            triggered,
  output logic            capture_done,
  output logic [AW-1:0]   trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRETRIG  = 3'd1,
    S_ARMED    = 3'd2,
    S_POSTTRIG = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [AW-1:0]   ONE_AW   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]     ONE_POST = {{AW{1'b0}}, 1'b1};
  localparam logic [DECW-1:0] ONE_DEC  = {{(DECW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);

  state_t          r_state;
  logic            r_en;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic            r_rd_valid;
  logic            r_armed;
  logic            r_triggered;
  logic            r_done;
  logic [AW-1:0]   r_trig_addr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_pre_cnt;
  logic [AW:0]     r_post_cnt;
  logic [DECW-1:0] r_div_cnt;
  logic [AW-1:0]   r_trig_pos_l;
  logic [DECW-1:0] r_dec_l;
  logic            r_src_l;
  logic            r_edge_l;
  // [0],[1] = synchronizer stages, [2] = previous synchronized value
  logic [2:0]      r_t1_sync;
  logic [2:0]      r_t2_sync;

  logic            w_sel_cur;
  logic            w_sel_prev;
  logic            w_edge;
  logic            w_event;
  logic            w_tick;
  logic            w_sampling;
  logic [AW-1:0]   w_wr_ptr_inc;
  logic [AW-1:0]   w_pre_inc;
  logic [AW-1:0]   w_rd_addr;
  logic [AW:0]     w_post_init;

  assign w_tick       = (r_div_cnt == {DECW{1'b0}});
  assign w_sampling   = (r_state == S_PRETRIG) || (r_state == S_ARMED) ||
                        (r_state == S_POSTTRIG);
  assign w_wr_ptr_inc = r_wr_ptr + ONE_AW;
  assign w_pre_inc    = r_pre_cnt + ONE_AW;
  // Oldest sample sits trig_pos entries before the trigger sample; AW-bit math wraps mod DEPTH.
  assign w_rd_addr    = r_trig_addr - r_trig_pos_l + ram.rd_idx;
  assign w_post_init  = DEPTH_W - {1'b0, r_trig_pos_l};

  // Select the latched trigger source and detect the latched edge polarity.
  always_comb begin
    w_sel_cur  = 1'b0;
    w_sel_prev = 1'b0;
    if (r_src_l) begin
      w_sel_cur  = r_t2_sync[1];
      w_sel_prev = r_t2_sync[2];
    end else begin
      w_sel_cur  = r_t1_sync[1];
      w_sel_prev = r_t1_sync[2];
    end
    if (r_edge_l) begin
      w_edge = w_sel_prev & ~w_sel_cur;
    end else begin
      w_edge = ~w_sel_prev & w_sel_cur;
    end
    w_event = w_edge | force_trig;
  end

  // Two-flop synchronizers for the asynchronous comparator outputs plus history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t1_sync <= 3'b000;
      r_t2_sync <= 3'b000;
    end else begin
      r_t1_sync <= {r_t1_sync[1:0], trig1};
      r_t2_sync <= {r_t2_sync[1:0], trig2};
    end
  end

  // Capture FSM with registered RAM strobes and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_en         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= {AW{1'b0}};
      r_rd_valid   <= 1'b0;
      r_armed      <= 1'b0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
      r_trig_addr  <= {AW{1'b0}};
      r_wr_ptr     <= {AW{1'b0}};
      r_pre_cnt    <= {AW{1'b0}};
      r_post_cnt   <= {(AW+1){1'b0}};
      r_div_cnt    <= {DECW{1'b0}};
      r_trig_pos_l <= {AW{1'b0}};
      r_dec_l      <= {DECW{1'b0}};
      r_src_l      <= 1'b0;
      r_edge_l     <= 1'b0;
    end else if (abort) begin
      // Abort beats start and trigger; the buffer contents are abandoned.
      r_state     <= S_IDLE;
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      // Only readback produces en without we, so data is valid the cycle after.
      r_rd_valid <= r_en & ~r_we;
      if (w_sampling) begin
        if (w_tick) begin
          r_div_cnt <= r_dec_l;
          r_en      <= 1'b1;
          r_we      <= 1'b1;
          r_addr    <= r_wr_ptr;
          r_wr_ptr  <= w_wr_ptr_inc;
        end else begin
          r_div_cnt <= r_div_cnt - ONE_DEC;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_capture) begin
            r_trig_pos_l <= trig_pos;
            r_dec_l      <= decimate;
            r_src_l      <= trig_src;
            r_edge_l     <= trig_edge;
            r_div_cnt    <= decimate;
            r_wr_ptr     <= {AW{1'b0}};
            r_pre_cnt    <= {AW{1'b0}};
            r_done       <= 1'b0;
            r_triggered  <= 1'b0;
            if (trig_pos == {AW{1'b0}}) begin
              r_state <= S_ARMED;
              r_armed <= 1'b1;
            end else begin
              r_state <= S_PRETRIG;
              r_armed <= 1'b0;
            end
          end else if ((r_state == S_DONE) && ram.rd_req) begin
            r_en   <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= w_rd_addr;
          end
        end
        S_PRETRIG: begin
          if (w_tick) begin
            r_pre_cnt <= w_pre_inc;
            if (w_pre_inc == r_trig_pos_l) begin
              r_state <= S_ARMED;
              r_armed <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (w_event) begin
            // A coincident write consumes the current pointer; the trigger sample is the next one.
            r_trig_addr <= w_tick ? w_wr_ptr_inc : r_wr_ptr;
            r_post_cnt  <= w_post_init;
            r_state     <= S_POSTTRIG;
            r_armed     <= 1'b0;
            r_triggered <= 1'b1;
          end
        end
        S_POSTTRIG: begin
          if (w_tick) begin
            r_post_cnt <= r_post_cnt - ONE_POST;
            if (r_post_cnt == ONE_POST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_armed     <= 1'b0;
          r_triggered <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign ram.en       = r_en;
  assign ram.we       = r_we;
  assign ram.addr     = r_addr;
  assign ram.rd_valid = r_rd_valid;
  assign armed        = r_armed;
  assign triggered    = r_triggered;
  assign capture_done = r_done;
  assign trig_addr    = r_trig_addr;

endmodule
